// File: rtl/vga_pkg.sv
// Shared frame-buffer constants, RGB332 pixel layout, arbiter grant encoding
// and fill-sequencer state encoding for the VRAM arbiter slice.
package vga_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 8;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CPU,
    GNT_FILL
  } gnt_e;

  typedef enum logic {
    FS_IDLE,
    FS_FILL
  } fill_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester/memory bus of the VRAM arbiter: scanout reads, CPU writes,
// fill control and the single-port memory side.
interface vram_arbiter_if #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int PIX_W  = vga_pkg::PIX_W
);
  // CPU writes use valid/ready: wr_valid with stable wr_addr/wr_data is held
  // until a cycle where wr_ready=1; that cycle is the transfer. Scanout reads
  // are fire-and-forget: disp_req in N returns disp_rvalid/disp_rdata in N+2.
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic [PIX_W-1:0]  disp_rdata;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;
  logic              wr_err;
  logic              fill_start;
  logic [PIX_W-1:0]  fill_color;
  logic              fill_busy;
  logic              fill_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           fill_start, fill_color, mem_rdata,
    input  disp_rvalid, disp_rdata, wr_ready, wr_err, fill_busy, fill_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           fill_start, fill_color, mem_rdata,
    output disp_rvalid, disp_rdata, wr_ready, wr_err, fill_busy, fill_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vram_fill_seq.sv
// Full-frame fill sequencer: IDLE/FILL FSM plus address counter. Requests the
// memory while in FILL and advances one pixel per grant.
module vram_fill_seq
  import vga_pkg::*;
#(
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int PIX_W    = vga_pkg::PIX_W,
  parameter int FB_DEPTH = vga_pkg::FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [PIX_W-1:0]  i_color,
  input  logic              i_gnt,
  output fill_state_e       o_state,
  output logic [ADDR_W-1:0] o_addr,
  output logic [PIX_W-1:0]  o_color,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  fill_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [PIX_W-1:0]  r_color, w_color_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FS_IDLE;
      r_addr  <= '0;
      r_color <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_color <= w_color_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // A start during FILL is ignored; the done pulse lands in IDLE so a start
  // coinciding with it begins a fresh frame.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_color_nxt = r_color;
    w_done_nxt  = 1'b0;
    case (r_state)
      FS_IDLE: begin
        if (i_start) begin
          w_state_nxt = FS_FILL;
          w_addr_nxt  = '0;
          w_color_nxt = i_color;
        end
      end
      FS_FILL: begin
        if (i_gnt) begin
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = FS_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
          end
        end
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  assign o_state = r_state;
  assign o_addr  = r_addr;
  assign o_color = r_color;
  assign o_done  = r_done;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: scanout reads have absolute priority; CPU writes and the fill
// engine share remaining cycles round-robin. Optional macro VRAM_ARB_STATS_EN.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int PIX_W    = vga_pkg::PIX_W,
  parameter int FB_DEPTH = vga_pkg::FB_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  vram_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fill_cycles
`endif
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);

  gnt_e              w_gnt;
  fill_state_e       w_fill_state;
  logic              w_fill_busy;
  logic              w_fill_done;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [PIX_W-1:0]  w_fill_color;
  logic              w_wr_in_range;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [PIX_W-1:0]  w_wdata_sel;

  logic              r_rr_cpu;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [PIX_W-1:0]  r_mem_wdata;
  logic              r_wr_err;
  logic              r_disp_rvalid;

  vram_fill_seq #(
    .ADDR_W  (ADDR_W),
    .PIX_W   (PIX_W),
    .FB_DEPTH(FB_DEPTH)
  ) u_fill (
    .clk    (clk),
    .rst    (rst),
    .i_start(bus.fill_start),
    .i_color(bus.fill_color),
    .i_gnt  (w_gnt == GNT_FILL),
    .o_state(w_fill_state),
    .o_addr (w_fill_addr),
    .o_color(w_fill_color),
    .o_done (w_fill_done)
  );

  assign w_fill_busy   = (w_fill_state == FS_FILL);
  assign w_wr_in_range = (bus.wr_addr < DEPTH_A);

  // r_rr_cpu=1 means the CPU wins the next cycle both writers contend.
  always_comb begin
    w_gnt = GNT_NONE;
    if (bus.disp_req) begin
      w_gnt = GNT_DISP;
    end else if (bus.wr_valid && w_fill_busy) begin
      w_gnt = r_rr_cpu ? GNT_CPU : GNT_FILL;
    end else if (bus.wr_valid) begin
      w_gnt = GNT_CPU;
    end else if (w_fill_busy) begin
      w_gnt = GNT_FILL;
    end
  end

  always_comb begin
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    case (w_gnt)
      GNT_DISP: w_addr_sel = bus.disp_addr;
      GNT_CPU: begin
        w_addr_sel  = bus.wr_addr;
        w_wdata_sel = bus.wr_data;
      end
      GNT_FILL: begin
        w_addr_sel  = w_fill_addr;
        w_wdata_sel = w_fill_color;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_cpu      <= 1'b1;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_wr_err      <= 1'b0;
      r_disp_rvalid <= 1'b0;
    end else begin
      r_mem_en      <= (w_gnt == GNT_DISP) || (w_gnt == GNT_FILL) ||
                       ((w_gnt == GNT_CPU) && w_wr_in_range);
      r_mem_we      <= (w_gnt == GNT_FILL) || ((w_gnt == GNT_CPU) && w_wr_in_range);
      r_mem_addr    <= w_addr_sel;
      r_mem_wdata   <= w_wdata_sel;
      r_wr_err      <= (w_gnt == GNT_CPU) && !w_wr_in_range;
      r_disp_rvalid <= r_mem_en && !r_mem_we;
      if (w_gnt == GNT_CPU) begin
        r_rr_cpu <= 1'b0;
      end else if (w_gnt == GNT_FILL) begin
        r_rr_cpu <= 1'b1;
      end
    end
  end

  assign bus.wr_ready    = (w_gnt == GNT_CPU);
  assign bus.wr_err      = r_wr_err;
  assign bus.fill_busy   = w_fill_busy;
  assign bus.fill_done   = w_fill_done;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.disp_rvalid = r_disp_rvalid;
  // Memory data arrives one cycle after the read strobe; pass it straight through.
  assign bus.disp_rdata  = r_disp_rvalid ? bus.mem_rdata : '0;

`ifdef VRAM_ARB_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fill_cycles;

  always_ff @(posedge clk) begin
    if (rst || bus.fill_start) begin
      r_stall_cnt   <= '0;
      r_fill_cycles <= '0;
    end else begin
      if (bus.wr_valid && (w_gnt != GNT_CPU) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_fill_busy && (r_fill_cycles != '1)) begin
        r_fill_cycles <= r_fill_cycles + 32'd1;
      end
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign fill_cycles = r_fill_cycles;
`endif

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port RGB332 frame buffer (640x480, 8-bit pixels) between three requesters: the VGA scanout reader, a CPU write port, and an internal fill engine.
- Scanout always has absolute priority. The CPU write port and the fill engine share the remaining cycles round-robin.
- Sits between the VGA timing/scanout logic and the vram storage inside TOP. All memory-side outputs are registered.

Parameters:
- ADDR_W, 19, pixel address width.
- PIX_W, 8, pixel width: r[7:5], g[4:2], b[1:0].
- FB_DEPTH, 307200, number of valid pixel addresses (640*480).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  scanout read request, this cycle
- disp_addr  in  ADDR_W  scanout pixel address
- disp_rvalid  out  1  scanout read data valid
- disp_rdata  out  PIX_W  scanout pixel data
- wr_valid  in  1  CPU write request
- wr_addr  in  ADDR_W  CPU write address
- wr_data  in  PIX_W  CPU write pixel
- wr_ready  out  1  CPU write accepted this cycle (combinational)
- wr_err  out  1  one-cycle pulse: accepted write had addr >= FB_DEPTH
- fill_start  in  1  start a full-frame fill
- fill_color  in  PIX_W  fill pixel, sampled on start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after last fill write issued
- mem_en  out  1  memory access enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  PIX_W  memory write data (registered)
- mem_rdata  in  PIX_W  memory read data, one cycle after mem_en and !mem_we

Behaviour:
- Reset values: all outputs 0; round-robin pointer = CPU; fill FSM = IDLE; fill address = 0.
- Arbitration (decided in cycle N; mem_* outputs show the result in N+1):
  - disp_req = 1: display granted. wr_ready = 0, fill stalls.
  - Otherwise, if only one writer is requesting, it is granted.
  - If both writers are requesting, the one not granted last wins. The pointer updates only on a writer grant.
  - No request: mem_en = 0 in N+1.
- Display read latency: disp_req in cycle N -> mem_en=1, mem_we=0 in N+1 -> disp_rvalid=1 and disp_rdata=mem_rdata in N+2. Back-to-back requests give one result per cycle, in order.
- CPU write: the transfer happens on wr_valid & wr_ready.
  - addr < FB_DEPTH: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in N+1.
  - addr >= FB_DEPTH: the write is still accepted, but mem_en=0 and wr_err=1 in N+1.
- Fill FSM, states IDLE / FILL:
  - IDLE -> FILL on fill_start. Latches fill_color, sets addr=0, fill_busy=1 from the next cycle.
  - In FILL, each granted cycle writes fill_color to addr, then increments addr.
  - When the write at addr FB_DEPTH-1 is granted: return to IDLE, fill_busy=0, fill_done=1 in the following cycle.
  - fill_start while in FILL is ignored.
  - fill_start in the same cycle as the fill_done pulse starts a new fill.
- Simultaneous events:
  - Display plus both writers: display wins; the round-robin pointer is unchanged.
  - Fill and CPU to the same address in alternate cycles: memory order equals grant order.
- Reset mid-fill or mid-read: takes effect on the next clk edge. FSM returns to IDLE, pending disp_rvalid is dropped (0), fill_done is not pulsed.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt (32-bit): counts cycles with wr_valid & !wr_ready.
  - fill_cycles (32-bit): counts cycles with fill_busy=1.
  - Both counters saturate at all-ones and clear on rst or on fill_start.
- When undefined, these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package vga_pkg:
  - constants H_RES=640, V_RES=480, FB_DEPTH, ADDR_W, PIX_W;
  - typedef pixel_t (RGB332, with r/g/b field widths 3/3/2);
  - grant enum {GNT_NONE, GNT_DISP, GNT_CPU, GNT_FILL}.
- One sub-module, vram_fill_seq: the fill FSM and address counter, with a req/gnt interface to the arbiter core.

Test Plan:
- After reset, fill_start with fill_color=8'hFF and no other requests -> 307200 writes, addr 0..307199, fill_done pulses 307201 cycles after start; then read addr 0 and 307199 -> disp_rdata=8'hFF.
- Continuous wr_valid and fill active, no disp_req -> grants alternate CPU, FILL, CPU...; each sees wr_ready/grant every other cycle.
- disp_req held for 640 cycles during a fill -> fill_busy stays 1, fill address frozen, wr_ready=0 throughout; disp_rvalid train is 640 cycles long, delayed by 2.
- CPU write addr=19'd307200, data 8'hE0 -> wr_ready=1, wr_err=1 next cycle, mem_en=0.
- rst asserted at fill address 1000 -> fill_busy=0 next cycle, no fill_done; a new fill_start restarts from addr 0.
- CPU write 8'h1C to addr 5, then disp_req addr 5 -> disp_rdata=8'h1C exactly 2 cycles after the request.
